// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and
// data access. Data has priority; a saturating starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants made while fetch waited.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner_dm;    // 1: data port owns the current transaction
  logic             lat_we;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_full;
  logic             grant_if;
  logic             grant_dm;

  assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration, next state and per-state outputs
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    mem_valid = 1'b0;
    if_done   = 1'b0;
    dm_done   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req && (!dm_req || starve_full)) begin
          grant_if  = 1'b1;
          state_nxt = ISSUE;
        end else if (dm_req) begin
          grant_dm  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          state_nxt = lat_we ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        // No arbitration here so a requester's stale req is never re-granted.
        if_done   = ~owner_dm;
        dm_done   = owner_dm;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    mem_we = lat_we & mem_valid;
  end

  // Transaction capture at grant, starvation counting and read data return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_dm   <= 1'b0;
      lat_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant_if) begin
        // Fetch is always a read and carries zero write data.
        owner_dm   <= 1'b0;
        lat_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        starve_cnt <= '0;
      end else if (grant_dm) begin
        owner_dm  <= 1'b1;
        lat_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        if (if_req && !starve_full) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end
      if (state == WAIT && mem_rvalid) begin
        if (owner_dm) begin
          dm_rdata <= mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter with a transaction-level
// reference model compared against the DUT on every cycle.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;

  // memory side: either directed values or an automatic responder
  logic              auto_mem = 1'b0;
  logic              d_ready = 1'b0;
  logic              d_rvalid = 1'b0;
  logic [DATA_W-1:0] d_rdata = '0;
  logic              a_rvalid = 1'b0;
  logic [DATA_W-1:0] a_rdata = '0;

  assign mem_ready  = auto_mem ? 1'b1 : d_ready;
  assign mem_rvalid = auto_mem ? a_rvalid : d_rvalid;
  assign mem_rdata  = auto_mem ? a_rdata : d_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // automatic memory: always ready, returns read data one cycle after acceptance
  always @(posedge clk) begin
    logic              acc;
    logic [ADDR_W-1:0] a;
    acc = mem_valid && mem_ready && !mem_we;
    a   = mem_addr;
    #2;
    a_rvalid = acc;
    a_rdata  = acc ? mem_fn(a) : '0;
  end

  // reference model: one transaction record, updated per clock
  logic              m_busy, m_sent, m_done_due, m_dm, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_if_rdata, m_dm_rdata;
  int                m_starve;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_sent = 0; m_done_due = 0; m_dm = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
      m_starve = 0;
    end else if (m_done_due) begin
      m_done_due = 0;
    end else if (!m_busy) begin
      if (if_req && (!dm_req || m_starve == STARVE_MAX)) begin
        m_busy = 1; m_sent = 0; m_dm = 0; m_we = 0;
        m_addr = if_addr; m_wdata = '0; m_starve = 0;
      end else if (dm_req) begin
        m_busy = 1; m_sent = 0; m_dm = 1; m_we = dm_we;
        m_addr = dm_addr; m_wdata = dm_wdata;
        if (if_req) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      end
    end else if (!m_sent) begin
      if (mem_ready) begin
        if (m_we) begin
          m_busy = 0; m_done_due = 1;
        end else begin
          m_sent = 1;
        end
      end
    end else if (mem_rvalid) begin
      if (m_dm) m_dm_rdata = mem_rdata;
      else      m_if_rdata = mem_rdata;
      m_busy = 0; m_sent = 0; m_done_due = 1;
    end
  end

  // per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    logic e_valid, e_if_done, e_dm_done;
    if (chk_en) begin
      e_valid   = m_busy && !m_sent;
      e_if_done = m_done_due && !m_dm;
      e_dm_done = m_done_due && m_dm;
      cmp("m_mem_valid", mem_valid, e_valid);
      cmp("m_mem_we", mem_we, e_valid && m_we);
      cmp("m_mem_addr", mem_addr, m_addr);
      cmp("m_mem_wdata", mem_wdata, m_wdata);
      cmp("m_if_done", if_done, e_if_done);
      cmp("m_dm_done", dm_done, e_dm_done);
      cmp("m_if_rdata", if_rdata, m_if_rdata);
      cmp("m_dm_rdata", dm_rdata, m_dm_rdata);
      cmp("m_stall", stall, (if_req && !e_if_done) || (dm_req && !e_dm_done));
      cmp("m_starve", 64'(dut.starve_cnt), 64'(m_starve));
    end
  end

  // grant log: address and starvation count seen when a request is issued
  logic [ADDR_W-1:0] glog[$];
  int                slog[$];
  logic              prev_v = 1'b0;
  always @(negedge clk) begin
    if (mem_valid && !prev_v) begin
      glog.push_back(mem_addr);
      slog.push_back(int'(dut.starve_cnt));
    end
    prev_v = mem_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic id, dd, if_fin, dm_fin, fin;
    logic [ADDR_W-1:0] exp_g[6];
    int exp_s[6];

    rst = 1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0;
    tick();
    chk_en = 1;
    @(negedge clk);
    cmp("rst_valid", mem_valid, 0);
    cmp("rst_if_rdata", if_rdata, 0);
    cmp("rst_dm_rdata", dm_rdata, 0);
    cmp("rst_addr", mem_addr, 0);
    cmp("rst_done", {if_done, dm_done}, 0);
    tick(); rst = 0;
    tick();

    // fetch read with zero wait
    if_addr = 32'h100; if_req = 1; d_ready = 1;
    @(negedge clk);
    cmp("fr_c0_stall", stall, 1);
    cmp("fr_c0_valid", mem_valid, 0);
    tick();
    @(negedge clk);
    cmp("fr_c1_valid", mem_valid, 1);
    cmp("fr_c1_addr", mem_addr, 32'h100);
    cmp("fr_c1_we", mem_we, 0);
    cmp("fr_c1_stall", stall, 1);
    tick(); d_ready = 0; d_rvalid = 1; d_rdata = 32'hDEADBEEF;
    @(negedge clk);
    cmp("fr_c2_stall", stall, 1);
    cmp("fr_c2_done", if_done, 0);
    tick(); d_rvalid = 0; d_rdata = '0;
    @(negedge clk);
    cmp("fr_c3_done", if_done, 1);
    cmp("fr_c3_rdata", if_rdata, 32'hDEADBEEF);
    cmp("fr_c3_stall", stall, 0);
    tick(); if_req = 0;
    @(negedge clk);
    cmp("fr_c4_done", if_done, 0);
    cmp("fr_c4_valid", mem_valid, 0);

    // spurious rvalid while idle
    tick(); d_rvalid = 1; d_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmp("sp_if_rdata", if_rdata, 32'hDEADBEEF);
      cmp("sp_dm_rdata", dm_rdata, 0);
      cmp("sp_done", {if_done, dm_done}, 0);
      tick();
    end
    d_rvalid = 0; d_rdata = '0;

    // simultaneous requests: data first, then fetch
    auto_mem = 1;
    tick();
    glog.delete(); slog.delete();
    if_addr = 32'h300; if_req = 1;
    dm_addr = 32'h600; dm_we = 0; dm_req = 1;
    if_fin = 0; dm_fin = 0;
    for (int c = 0; c < 100 && !(if_fin && dm_fin); c++) begin
      @(negedge clk); id = if_done; dd = dm_done;
      tick();
      if (id) begin if_req = 0; if_fin = 1; end
      if (dd) begin dm_req = 0; dm_fin = 1; end
    end
    cmp("sim_complete", {if_fin, dm_fin}, 2'b11);
    cmp("sim_ngrants", glog.size(), 2);
    cmp("sim_first", glog[0], 32'h600);
    cmp("sim_second", glog[1], 32'h300);
    cmp("sim_starve0", slog[0], 1);
    cmp("sim_starve1", slog[1], 0);
    cmp("sim_if_rdata", if_rdata, 32'hA5A50300);
    cmp("sim_dm_rdata", dm_rdata, 32'hA5A50600);

    // data write with three cycles of back-pressure
    auto_mem = 0; d_ready = 0;
    tick();
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'h12345678;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) d_ready = 1;
      @(negedge clk);
      cmp("wr_valid", mem_valid, 1);
      cmp("wr_we", mem_we, 1);
      cmp("wr_addr", mem_addr, 32'h2000);
      cmp("wr_wdata", mem_wdata, 32'h12345678);
      cmp("wr_done_early", dm_done, 0);
    end
    tick(); d_ready = 0;
    @(negedge clk);
    cmp("wr_done", dm_done, 1);
    cmp("wr_valid_off", {mem_valid, mem_we}, 0);
    cmp("wr_dm_rdata", dm_rdata, 32'hA5A50600);
    cmp("wr_stall", stall, 0);
    tick(); dm_req = 0; dm_we = 0;
    @(negedge clk);
    cmp("wr_done_once", dm_done, 0);

    // starvation: continuous data requests while fetch waits
    auto_mem = 1;
    tick();
    glog.delete(); slog.delete();
    if_addr = 32'h400; if_req = 1;
    dm_addr = 32'h800; dm_we = 0; dm_req = 1;
    fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk); id = if_done; dd = dm_done;
      tick();
      if (id) if_req = 0;
      if (dd) begin
        if (glog.size() >= 6) begin dm_req = 0; fin = 1; end
        else dm_addr = dm_addr + 32'd4;
      end
    end
    cmp("st_complete", fin, 1);
    cmp("st_ngrants", glog.size(), 6);
    exp_g = '{32'h800, 32'h804, 32'h808, 32'h80C, 32'h400, 32'h810};
    exp_s = '{1, 2, 3, 4, 0, 0};
    for (int k = 0; k < 6; k++) begin
      cmp("st_grant_addr", glog[k], exp_g[k]);
      cmp("st_starve", slog[k], exp_s[k]);
    end
    cmp("st_if_rdata", if_rdata, 32'hA5A50400);
    cmp("st_dm_rdata", dm_rdata, 32'hA5A50810);

    // reset while waiting for read data
    auto_mem = 0;
    tick();
    if_addr = 32'h500; if_req = 1; d_ready = 1;
    tick();
    @(negedge clk);
    cmp("rr_issue", mem_valid, 1);
    tick(); d_ready = 0;
    #1 rst = 1; if_req = 0;
    @(negedge clk);
    cmp("rr_valid", mem_valid, 0);
    cmp("rr_if_rdata", if_rdata, 0);
    cmp("rr_dm_rdata", dm_rdata, 0);
    tick(); rst = 0; d_rvalid = 1; d_rdata = 32'hCAFEF00D;
    @(negedge clk);
    cmp("rr_no_done", {if_done, dm_done}, 0);
    tick(); d_rvalid = 0; d_rdata = '0;
    @(negedge clk);
    cmp("rr_no_done2", {if_done, dm_done}, 0);
    cmp("rr_if_rdata2", if_rdata, 0);
    cmp("rr_idle", mem_valid, 0);
    tick();
    @(negedge clk);
    cmp("rr_no_done3", {if_done, dm_done}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
